// File: rtl/circuit1_operand_seq_if.sv
// Bundles the byte stream, operand and result handshake signals of circuit1_operand_seq.
// master: the sequencer itself; slave: the surrounding producer/datapath/consumer.
interface circuit1_operand_seq_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0]   in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATAWIDTH-1:0]   a;
  logic [DATAWIDTH-1:0]   b;
  logic [DATAWIDTH-1:0]   c;
  logic                   op_valid;
  logic [2*DATAWIDTH-1:0] x_in;
  logic [DATAWIDTH-1:0]   z_in;
  logic [3*DATAWIDTH-1:0] res_data;
  logic                   res_valid;
  logic                   res_ready;

  modport master (
    input  in_data, in_valid, x_in, z_in, res_ready,
    output in_ready, a, b, c, op_valid, res_data, res_valid
  );

  modport slave (
    output in_data, in_valid, x_in, z_in, res_ready,
    input  in_ready, a, b, c, op_valid, res_data, res_valid
  );
endinterface

// File: rtl/circuit1_operand_seq.sv
// Byte-stream to (a, b, c) operand feeder with triple FIFO, fixed-latency issue and result capture.
// Optional handshake counter output result_count enabled by defining CIRCUIT1_OPSEQ_STATS_EN.
module circuit1_operand_seq #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef CIRCUIT1_OPSEQ_STATS_EN
  output logic [15:0]            result_count,
`endif
  circuit1_operand_seq_if.master bus
);

  localparam int unsigned TripleW = 3 * DATAWIDTH;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StGetA, StGetB, StGetC} asm_state_e;
  typedef enum logic [1:0] {StIdle, StWait, StHold} iss_state_e;

  // Assembler state
  asm_state_e           asm_q, asm_d;
  logic [DATAWIDTH-1:0] part_a_q, part_a_d;
  logic [DATAWIDTH-1:0] part_b_q, part_b_d;

  // Triple FIFO
  logic [TripleW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]        count_q, count_d;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic [TripleW-1:0]   head;

  // Issue state and registered outputs
  iss_state_e           iss_q, iss_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic [DATAWIDTH-1:0] c_q, c_d;
  logic                 op_valid_q, op_valid_d;
  logic [TripleW-1:0]   res_data_q, res_data_d;
  logic                 res_valid_q, res_valid_d;

  logic                 accept;

  assign fifo_full  = (count_q == (PtrW + 1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // Full is the registered count, so a same-cycle pop never makes room for this push.
  assign bus.in_ready = (asm_q != StGetC) || !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && (asm_q == StGetC);

  always_comb begin
    asm_d    = asm_q;
    part_a_d = part_a_q;
    part_b_d = part_b_q;
    if (accept) begin
      case (asm_q)
        StGetA: begin
          part_a_d = bus.in_data;
          asm_d    = StGetB;
        end
        StGetB: begin
          part_b_d = bus.in_data;
          asm_d    = StGetC;
        end
        StGetC:  asm_d = StGetA;
        default: asm_d = StGetA;
      endcase
    end
  end

  always_comb begin
    iss_d       = iss_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    op_valid_d  = op_valid_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    case (iss_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          {a_d, b_d, c_d} = head;
          op_valid_d      = 1'b1;
          cnt_d           = CntW'(LATENCY);
          iss_d           = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          res_data_d  = {bus.x_in, bus.z_in};
          res_valid_d = 1'b1;
          iss_d       = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          op_valid_d  = 1'b0;
          iss_d       = StIdle;
        end
      end
      default: iss_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {part_a_q, part_b_q, bus.in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q       <= StGetA;
      part_a_q    <= '0;
      part_b_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      iss_q       <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_valid_q  <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      part_a_q    <= part_a_d;
      part_b_q    <= part_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      iss_q       <= iss_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      op_valid_q  <= op_valid_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;

`ifdef CIRCUIT1_OPSEQ_STATS_EN
  logic [15:0] result_count_q, result_count_d;

  always_comb begin
    result_count_d = result_count_q;
    if (res_valid_q && bus.res_ready && (result_count_q != 16'hFFFF)) begin
      result_count_d = result_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) result_count_q <= '0;
    else      result_count_q <= result_count_d;
  end

  assign result_count = result_count_q;
`endif

endmodule
